// File: rtl/count_sequencer.sv
// Sequencer for a WIDTH-bit up counter: start loads a terminal value, the block
// counts 0..limit and pulses done, with one-shot/auto-reload, pause/resume and abort.
module count_sequencer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             reload_mode,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_ILL   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    limit_d   = limit_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d       = '0;
          overrun_d = 1'b0;
          if (limit == '0) begin
            done_d = 1'b1;
          end else begin
            limit_d  = limit;
            reload_d = reload_mode;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          q_d     = '0;
          state_d = S_IDLE;
        end else begin
          if (start) overrun_d = 1'b1;
          // Pause beats terminal count; done is deferred until after resume
          if (pause) begin
            state_d = S_PAUSE;
          end else if (q_q == limit_q) begin
            done_d = 1'b1;
            if (reload_q) q_d = '0;
            else          state_d = S_IDLE;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
      end
      S_PAUSE: begin
        if (abort) begin
          q_d     = '0;
          state_d = S_IDLE;
        end else begin
          if (start)  overrun_d = 1'b1;
          if (!pause) state_d   = S_RUN;
        end
      end
      default: begin
        q_d     = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      limit_q   <= '0;
      reload_q  <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      limit_q   <= limit_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign q       = q_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state   = state_q;
  assign overrun = overrun_q;

endmodule
